// File: rtl/zap_fetch_pkg.sv
// Shared types, breakpoint patterns and the 2-bit predictor transition
// function for the fetch queue.
package zap_fetch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_8;
    logic        abort;
    bp_state_t   taken;
  } fetch_entry_t;

  localparam logic [31:0] BKPT   = 32'b1110_0001_0010_????_????_????_0111_????;
  localparam logic [15:0] T_BKPT = 16'b1011_1110_????_????;

  // A mispredict walks toward the opposite weak state; a confirm saturates.
  function automatic bp_state_t bp_next(input bp_state_t s, input logic mispredict);
    bp_state_t n;
    n = s;
    if (mispredict) begin
      case (s)
        SNT:     n = WNT;
        WNT:     n = WT;
        WT:      n = WNT;
        default: n = WT;
      endcase
    end else begin
      n = (s == SNT || s == WNT) ? SNT : ST;
    end
    return n;
  endfunction

endpackage

// File: rtl/zap_fetch_bp_table.sv
// Branch prediction state table: 2-bit flops, combinational read, synchronous
// write. Not reset; a read of the entry being written returns the old value.
module zap_fetch_bp_table
  import zap_fetch_pkg::*;
#(
  parameter int unsigned ENTRIES = 1024,
  localparam int unsigned IW = $clog2(ENTRIES)
) (
  input  logic          i_clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  bp_state_t     wdata,
  input  logic [IW-1:0] raddr,
  output bp_state_t     rdata
);

  bp_state_t mem [ENTRIES];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/zap_fetch_queue.sv
// Fetch stage between I-cache and decode: in-order queue of fetched words with
// PC, PC+8/+4, abort and predicted branch state; honours clear/stall priority.
module zap_fetch_queue
  import zap_fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BP_ENTRIES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_decode,
  input  logic        i_clear_from_decode,
  input  logic [31:0] i_pc_ff,
  input  logic        i_cpsr_ff_t,
  input  logic        i_valid,
  input  logic [31:0] i_instruction,
  input  logic        i_instr_abort,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic        o_instr_abort,
  output logic [31:0] o_pc_ff,
  output logic [31:0] o_pc_plus_8_ff,
  output logic [1:0]  o_taken,
  input  logic        i_confirm_from_alu,
  input  logic [31:0] i_pc_from_alu,
  input  logic [1:0]  i_taken
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(BP_ENTRIES);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  fetch_entry_t  q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          sleep;

  logic          down_stall, flush, hold, enq, deq;
  logic [31:0]   cap_instr;
  fetch_entry_t  new_entry;
  bp_state_t     rd_taken, wr_state;
  logic          bp_we;
  logic          unused_pc_bits;

  assign down_stall = i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
  assign o_ready    = !sleep && (count < FULL);
  assign o_valid    = (count != '0);

  // First matching condition wins; a downstream stall only blocks dequeue.
  always_comb begin
    flush = 1'b0;
    hold  = 1'b0;
    deq   = 1'b0;
    if (i_clear_from_writeback)  flush = 1'b1;
    else if (i_data_stall)       hold  = 1'b1;
    else if (i_clear_from_alu)   flush = 1'b1;
    else if (down_stall)         deq   = 1'b0;
    else if (i_clear_from_decode) flush = 1'b1;
    else                         deq   = o_valid;
    enq = i_valid && o_ready && !flush && !hold;
  end

  always_comb begin
    cap_instr           = i_pc_ff[1] ? {16'h0000, i_instruction[31:16]} : i_instruction;
    new_entry.instr     = cap_instr;
    new_entry.pc        = i_pc_ff;
    new_entry.pc_plus_8 = i_pc_ff + (i_cpsr_ff_t ? 32'd4 : 32'd8);
    new_entry.abort     = i_instr_abort
                        | (!i_cpsr_ff_t && (cap_instr ==? BKPT))
                        | ( i_cpsr_ff_t && (cap_instr[15:0] ==? T_BKPT));
    new_entry.taken     = rd_taken;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      sleep  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      sleep  <= 1'b0;
    end else if (!hold) begin
      if (enq) begin
        q[wr_ptr] <= new_entry;
        wr_ptr    <= wr_ptr + 1'b1;
        if (i_instr_abort) sleep <= 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_instruction  = q[rd_ptr].instr;
  assign o_pc_ff        = q[rd_ptr].pc;
  assign o_pc_plus_8_ff = q[rd_ptr].pc_plus_8;
  assign o_instr_abort  = q[rd_ptr].abort;
  assign o_taken        = q[rd_ptr].taken;

  assign bp_we    = !i_data_stall && !down_stall && (i_clear_from_alu || i_confirm_from_alu);
  assign wr_state = bp_next(bp_state_t'(i_taken), i_clear_from_alu);
  assign unused_pc_bits = ^{i_pc_from_alu[31:IW+1], i_pc_from_alu[0]};

  zap_fetch_bp_table #(.ENTRIES(BP_ENTRIES)) u_bp_table (
    .i_clk (i_clk),
    .we    (bp_we),
    .waddr (i_pc_from_alu[IW:1]),
    .wdata (wr_state),
    .raddr (i_pc_ff[IW:1]),
    .rdata (rd_taken)
  );

endmodule

// File: tb/tb_zap_fetch_queue.sv
// Randomized and directed bench for zap_fetch_queue against a queue-based
// behavioural model of the fetch stage.
module tb_zap_fetch_queue;

  localparam int DEPTH = 4;
  localparam int BPE   = 1024;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_clear_from_writeback = 1'b0, i_data_stall = 1'b0, i_clear_from_alu = 1'b0;
  logic        i_stall_from_shifter = 1'b0, i_stall_from_issue = 1'b0, i_stall_from_decode = 1'b0;
  logic        i_clear_from_decode = 1'b0;
  logic [31:0] i_pc_ff = '0;
  logic        i_cpsr_ff_t = 1'b0, i_valid = 1'b0, i_instr_abort = 1'b0;
  logic [31:0] i_instruction = '0;
  logic        i_confirm_from_alu = 1'b0;
  logic [31:0] i_pc_from_alu = '0;
  logic [1:0]  i_taken = '0;
  logic        o_ready, o_valid, o_instr_abort;
  logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
  logic [1:0]  o_taken;

  always #5 clk = ~clk;

  zap_fetch_queue #(.DEPTH(DEPTH), .BP_ENTRIES(BPE)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
    .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
    .i_stall_from_issue(i_stall_from_issue), .i_stall_from_decode(i_stall_from_decode),
    .i_clear_from_decode(i_clear_from_decode), .i_pc_ff(i_pc_ff), .i_cpsr_ff_t(i_cpsr_ff_t),
    .i_valid(i_valid), .i_instruction(i_instruction), .i_instr_abort(i_instr_abort),
    .o_ready(o_ready), .o_valid(o_valid), .o_instruction(o_instruction),
    .o_instr_abort(o_instr_abort), .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff),
    .o_taken(o_taken), .i_confirm_from_alu(i_confirm_from_alu),
    .i_pc_from_alu(i_pc_from_alu), .i_taken(i_taken)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        abort;
    logic [1:0]  taken;
  } ent_t;

  ent_t        mq[$];
  bit          msleep = 1'b0;
  bit          primed = 1'b0;
  logic [1:0]  mbp [BPE];
  logic [1:0]  mis_nx  [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
  logic [1:0]  conf_nx [4] = '{2'd0, 2'd0, 2'd3, 2'd3};

  ent_t        m_e;
  logic [31:0] m_sel;
  bit          m_ready, m_dstall;

  always @(negedge clk) begin
    if (primed) begin
      check("valid", 32'(o_valid), 32'(mq.size() != 0));
      check("ready", 32'(o_ready), 32'(!msleep && mq.size() < DEPTH));
      if (mq.size() != 0) begin
        check("instr", o_instruction, mq[0].instr);
        check("pc", o_pc_ff, mq[0].pc);
        check("pc8", o_pc_plus_8_ff, mq[0].pc8);
        check("abort", 32'(o_instr_abort), 32'(mq[0].abort));
        check("taken", 32'(o_taken), 32'(mq[0].taken));
      end
    end
    // Next state of the model for the coming rising edge.
    m_ready  = !msleep && mq.size() < DEPTH;
    m_dstall = i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode;
    m_sel    = i_pc_ff[1] ? {16'h0, i_instruction[31:16]} : i_instruction;
    m_e.instr = m_sel;
    m_e.pc    = i_pc_ff;
    m_e.pc8   = i_pc_ff + (i_cpsr_ff_t ? 32'd4 : 32'd8);
    m_e.abort = i_instr_abort
             || (!i_cpsr_ff_t && m_sel[31:20] == 12'hE12 && m_sel[7:4] == 4'h7)
             || ( i_cpsr_ff_t && m_sel[15:8] == 8'hBE);
    m_e.taken = mbp[i_pc_ff[10:1]];
    if (!i_data_stall && !m_dstall && (i_clear_from_alu || i_confirm_from_alu))
      mbp[i_pc_from_alu[10:1]] = i_clear_from_alu ? mis_nx[i_taken] : conf_nx[i_taken];
    if (i_reset) begin
      mq.delete(); msleep = 1'b0; primed = 1'b1;
    end else if (i_clear_from_writeback) begin
      mq.delete(); msleep = 1'b0;
    end else if (i_data_stall) begin
    end else if (i_clear_from_alu) begin
      mq.delete(); msleep = 1'b0;
    end else if (m_dstall) begin
      if (i_valid && m_ready) begin mq.push_back(m_e); if (i_instr_abort) msleep = 1'b1; end
    end else if (i_clear_from_decode) begin
      mq.delete(); msleep = 1'b0;
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (i_valid && m_ready) begin mq.push_back(m_e); if (i_instr_abort) msleep = 1'b1; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_reset = 0; i_clear_from_writeback = 0; i_data_stall = 0; i_clear_from_alu = 0;
    i_stall_from_shifter = 0; i_stall_from_issue = 0; i_stall_from_decode = 0;
    i_clear_from_decode = 0; i_valid = 0; i_instr_abort = 0; i_cpsr_ff_t = 0;
    i_confirm_from_alu = 0; i_instruction = 32'hE1A0_0000;
  endtask

  task automatic push_one(input logic [31:0] pc);
    i_valid = 1; i_pc_ff = pc; i_instruction = 32'hE1A0_0000;
    tick();
    i_valid = 0;
  endtask

  int k;
  bit acc;

  initial begin
    repeat (3) tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_instr", o_instruction, 32'd0);
    check("rst_pc", o_pc_ff, 32'd0);
    check("rst_pc8", o_pc_plus_8_ff, 32'd0);
    check("rst_taken", 32'(o_taken), 32'd0);
    check("rst_abort", 32'(o_instr_abort), 32'd0);
    idle();

    for (int i = 0; i < BPE; i++) begin
      i_confirm_from_alu = 1; i_pc_from_alu = 32'(i) << 1; i_taken = 2'($urandom_range(0, 3));
      tick();
    end
    idle();

    // Fill with decode stalled: four accepts, the fifth word is held off.
    i_stall_from_decode = 1; i_valid = 1; k = 0;
    for (int c = 0; c < 8; c++) begin
      i_pc_ff = 32'h100 + 32'(4 * k); i_instruction = 32'hE1A0_0000 + 32'(k);
      acc = o_ready;
      tick();
      if (acc) k++;
    end
    check("fill_accepts", 32'(k), 32'd4);
    check("fill_ready", 32'(o_ready), 32'd0);
    i_valid = 0; i_stall_from_decode = 0;
    for (int j = 0; j < 4; j++) begin
      check("fill_order_pc", o_pc_ff, 32'h100 + 32'(4 * j));
      check("fill_order_pc8", o_pc_plus_8_ff, 32'h108 + 32'(4 * j));
      tick();
    end
    check("fill_drained", 32'(o_valid), 32'd0);

    // Thumb breakpoint in the upper half.
    i_cpsr_ff_t = 1; i_valid = 1; i_pc_ff = 32'h202; i_instruction = 32'hBE01_1234;
    tick();
    i_valid = 0;
    check("thumb_instr", o_instruction, 32'h0000_BE01);
    check("thumb_abort", 32'(o_instr_abort), 32'd1);
    check("thumb_pc8", o_pc_plus_8_ff, 32'h206);
    check("thumb_ready", 32'(o_ready), 32'd1);
    i_cpsr_ff_t = 0;
    tick(); tick();
    check("thumb_nosleep", 32'(o_ready), 32'd1);

    // Prefetch abort puts the queue to sleep until a flush.
    i_valid = 1; i_pc_ff = 32'h300; i_instr_abort = 1;
    tick();
    i_valid = 0; i_instr_abort = 0;
    check("abort_flag", 32'(o_instr_abort), 32'd1);
    check("abort_sleep", 32'(o_ready), 32'd0);
    tick(); tick();
    check("abort_drained", 32'(o_valid), 32'd0);
    check("abort_still_asleep", 32'(o_ready), 32'd0);
    i_clear_from_decode = 1;
    tick();
    i_clear_from_decode = 0;
    check("abort_woken", 32'(o_ready), 32'd1);

    // data_stall outranks alu clear; wb clear outranks data_stall.
    i_stall_from_decode = 1;
    push_one(32'h400); push_one(32'h404);
    i_data_stall = 1; i_clear_from_alu = 1;
    tick();
    check("prio_hold_valid", 32'(o_valid), 32'd1);
    check("prio_hold_pc", o_pc_ff, 32'h400);
    i_clear_from_alu = 0; i_clear_from_writeback = 1;
    tick();
    check("prio_wb_flush", 32'(o_valid), 32'd0);
    idle();

    // Streaming through 3*DEPTH words wraps both pointers.
    i_valid = 1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      i_pc_ff = 32'h500 + 32'(4 * i);
      tick();
      check("wrap_head", o_pc_ff, 32'h500 + 32'(4 * i));
    end
    i_valid = 0;
    tick();

    // Prediction table updates at PC 0x40 (index 0x20).
    i_confirm_from_alu = 1; i_pc_from_alu = 32'h40; i_taken = 2'd2;
    tick();
    i_confirm_from_alu = 0;
    push_one(32'h40);
    check("bp_confirm_wt_st", 32'(o_taken), 32'd3);
    tick();
    i_clear_from_alu = 1; i_taken = 2'd3;
    tick();
    i_clear_from_alu = 0;
    push_one(32'h40);
    check("bp_mispredict_st_wt", 32'(o_taken), 32'd2);
    tick();
    i_clear_from_alu = 1; i_taken = 2'd0; i_stall_from_issue = 1;
    tick();
    i_clear_from_alu = 0; i_stall_from_issue = 0;
    push_one(32'h40);
    check("bp_stall_blocks", 32'(o_taken), 32'd2);
    tick();
    i_valid = 1; i_pc_ff = 32'h40; i_confirm_from_alu = 1; i_pc_from_alu = 32'h40; i_taken = 2'd3;
    tick();
    i_valid = 0; i_confirm_from_alu = 0;
    check("bp_read_old", 32'(o_taken), 32'd2);
    tick();
    push_one(32'h40);
    check("bp_read_new", 32'(o_taken), 32'd3);
    tick();

    // Randomized traffic, including mid-run resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      i_reset                = ($urandom_range(0, 999) < 3);
      i_clear_from_writeback = ($urandom_range(0, 99) < 2);
      i_data_stall           = ($urandom_range(0, 99) < 10);
      i_clear_from_alu       = ($urandom_range(0, 99) < 3);
      i_stall_from_shifter   = ($urandom_range(0, 99) < 5);
      i_stall_from_issue     = ($urandom_range(0, 99) < 5);
      i_stall_from_decode    = ($urandom_range(0, 99) < 8);
      i_clear_from_decode    = ($urandom_range(0, 99) < 3);
      i_valid                = ($urandom_range(0, 99) < 70);
      i_cpsr_ff_t            = ($urandom_range(0, 99) < 30);
      i_instr_abort          = ($urandom_range(0, 99) < 4);
      i_confirm_from_alu     = ($urandom_range(0, 99) < 10);
      i_pc_ff                = $urandom() & 32'hFFFF_FFFE;
      i_pc_from_alu          = $urandom();
      i_taken                = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      if (r < 10)      i_instruction = {12'hE12, 12'($urandom()), 4'h7, 4'($urandom())};
      else if (r < 17) i_instruction = {8'hBE, 24'($urandom())};
      else if (r < 24) i_instruction = {16'($urandom()), 8'hBE, 8'($urandom())};
      else             i_instruction = $urandom();
      tick();
    end
    idle();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
